// File: rtl/vin_pkg.sv
// rtl/vin_pkg.sv - shared constants and FSM states for the virtual-input link
package vin_pkg;

  localparam int N_KEYS     = 3;
  localparam int N_SWITCHES = 8;
  localparam int N_ITEMS    = 11;
  localparam int KEY_BASE   = 0;
  localparam int SW_BASE    = 3;
  localparam int IDX_W      = 4;
  localparam int VAL_BIT    = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    GAP
  } vin_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector over the 11 link items
module rr_pick
  import vin_pkg::*;
(
  input  logic [N_ITEMS-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [15:0]    req_ext;
  logic [IDX_W:0] pos;

  assign req_ext = {{(16 - N_ITEMS){1'b0}}, req};

  // Scan start, start+1, ... wrapping at N_ITEMS; first hit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int k = 0; k < N_ITEMS; k++) begin
      pos = {1'b0, start} + (IDX_W + 1)'(k);
      if (pos >= (IDX_W + 1)'(N_ITEMS)) begin
        pos = pos - (IDX_W + 1)'(N_ITEMS);
      end
      if (!valid && (pos < (IDX_W + 1)'(N_ITEMS)) && req_ext[pos[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/virtual_input_tx.sv
// rtl/virtual_input_tx.sv - transmit end of the number/control virtual-input link
module virtual_input_tx
  import vin_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int CNT_W        = 16
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic [N_KEYS-1:0]     key_req,
  input  logic [N_SWITCHES-1:0] sw_req,
  input  logic                  resync,
  output logic [4:0]            number,
  output logic                  control,
  output logic                  busy,
  output logic [CNT_W-1:0]      tx_count
);

  localparam int PH_W = 16;

  vin_state_t             state, state_next;
  logic [PH_W-1:0]        ph_cnt, ph_next;
  logic [N_ITEMS-1:0]     req, shadow, force_bits, pending;
  logic [IDX_W-1:0]       ptr, pick_idx, cur_idx;
  logic                   pick_valid, load_cmd, commit;

  assign req     = {sw_req, key_req};
  assign pending = (req ^ shadow) | force_bits;
  assign cur_idx = number[IDX_W-1:0];

  rr_pick u_pick (
    .req   (pending),
    .start (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      ph_cnt <= '0;
    end else begin
      state  <= state_next;
      ph_cnt <= ph_next;
    end
  end

  always_comb begin
    state_next = state;
    ph_next    = ph_cnt;
    load_cmd   = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          load_cmd   = 1'b1;
          state_next = SETUP;
          ph_next    = PH_W'(SETUP_CYCLES - 1);
        end
      end
      SETUP: begin
        if (ph_cnt == '0) begin
          state_next = STROBE;
          ph_next    = PH_W'(HOLD_CYCLES - 1);
        end else begin
          ph_next = ph_cnt - 1'b1;
        end
      end
      STROBE: begin
        if (ph_cnt == '0) begin
          commit     = 1'b1;
          state_next = GAP;
          ph_next    = PH_W'(GAP_CYCLES - 1);
        end else begin
          ph_next = ph_cnt - 1'b1;
        end
      end
      GAP: begin
        if (ph_cnt == '0) begin
          state_next = IDLE;
        end else begin
          ph_next = ph_cnt - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      number     <= '0;
      shadow     <= '0;
      force_bits <= '1;
      ptr        <= '0;
      tx_count   <= '0;
    end else begin
      if (load_cmd) begin
        number <= {req[pick_idx], pick_idx};
      end
      if (commit) begin
        shadow[cur_idx] <= number[VAL_BIT];
        ptr             <= (cur_idx == IDX_W'(N_ITEMS - 1)) ? '0 : cur_idx + 1'b1;
        tx_count        <= tx_count + 1'b1;
      end
      // A resync in the commit cycle must leave the item forced so it is resent.
      if (resync) begin
        force_bits <= '1;
      end else if (commit) begin
        force_bits[cur_idx] <= 1'b0;
      end
    end
  end

  assign control = (state == STROBE);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_virtual_input_tx.sv
// tb/tb_virtual_input_tx.sv - directed self-checking bench for virtual_input_tx
module tb_virtual_input_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  key_req;
  logic [7:0]  sw_req;
  logic        resync;
  logic [4:0]  number;
  logic        control;
  logic        busy;
  logic [15:0] tx_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_rise = 0;

  virtual_input_tx dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .key_req  (key_req),
    .sw_req   (sw_req),
    .resync   (resync),
    .number   (number),
    .control  (control),
    .busy     (busy),
    .tx_count (tx_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for one strobe, checks its word, length, stability and optionally its period.
  task automatic capture(input logic [4:0] exp_num, input string tag, input bit chk_period,
                         input int flip_at, input logic [7:0] flip_sw, input bit resync_gap);
    int w;
    int hold;
    logic [4:0] n;
    bit stable;
    w = 0;
    while (control !== 1'b1 && w < 60) begin
      @(negedge clk);
      w++;
    end
    check({tag, " timeout"}, 32'(w < 60), 32'd1);
    if (w < 60) begin
      if (chk_period) check({tag, " period"}, 32'(cyc - last_rise), 32'd8);
      last_rise = cyc;
      n = number;
      hold = 0;
      stable = 1'b1;
      while (control === 1'b1 && hold < 20) begin
        if (number !== n) stable = 1'b0;
        hold++;
        if (hold == flip_at) sw_req = flip_sw;
        @(negedge clk);
      end
      check({tag, " number"}, 32'(n), 32'(exp_num));
      check({tag, " hold"}, 32'(hold), 32'd4);
      check({tag, " stable"}, 32'(stable), 32'd1);
      if (resync_gap) begin
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    while (busy !== 1'b0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check({tag, " idle"}, 32'(w < 40), 32'd1);
  endtask

  initial begin
    logic [10:0] r;
    logic [3:0]  ix;
    bit          quiet;

    reset_n = 1'b0;
    key_req = 3'b000;
    sw_req  = 8'h00;
    resync  = 1'b0;
    #2;
    check("rst number", 32'(number), 32'd0);
    check("rst control", 32'(control), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst tx_count", 32'(tx_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: full push of zeros after reset
    for (int i = 0; i < 11; i++) begin
      capture(5'(i), $sformatf("t1 cmd%0d", i), i > 0, -1, 8'h00, 1'b0);
    end
    wait_idle("t1");
    check("t1 tx_count", 32'(tx_count), 32'd11);

    // 2: single switch change
    sw_req = 8'h01;
    capture(5'h13, "t2 cmd", 1'b0, -1, 8'h00, 1'b0);
    wait_idle("t2");
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) quiet = 1'b0;
    end
    check("t2 quiet", 32'(quiet), 32'd1);
    check("t2 tx_count", 32'(tx_count), 32'd12);

    // 3: request flips back during the strobe; latched value still goes out
    sw_req = 8'h00;
    capture(5'h03, "t3 first", 1'b0, 2, 8'h01, 1'b0);
    capture(5'h13, "t3 second", 1'b1, -1, 8'h00, 1'b0);
    wait_idle("t3");
    check("t3 tx_count", 32'(tx_count), 32'd14);

    // 4: ptr=4, items 2 and 10 pending together; 10 is reached first
    key_req = 3'b100;
    sw_req  = 8'h81;
    capture(5'h1A, "t4 first", 1'b0, -1, 8'h00, 1'b0);
    capture(5'h12, "t4 second", 1'b1, -1, 8'h00, 1'b0);
    wait_idle("t4");
    check("t4 tx_count", 32'(tx_count), 32'd16);

    // 5: resync during the gap of an unrelated command
    key_req = 3'b101;
    capture(5'h10, "t5 cmd", 1'b0, -1, 8'h00, 1'b1);
    r = {sw_req, key_req};
    for (int k = 0; k < 11; k++) begin
      ix = 4'((1 + k) % 11);
      capture({r[ix], ix}, $sformatf("t5 resend%0d", k), 1'b1, -1, 8'h00, 1'b0);
    end
    wait_idle("t5");
    check("t5 tx_count", 32'(tx_count), 32'd28);

    // 6: asynchronous reset in the middle of a strobe
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    begin
      int w;
      w = 0;
      while (control !== 1'b1 && w < 40) begin
        @(negedge clk);
        w++;
      end
      check("t6 reach strobe", 32'(w < 40), 32'd1);
    end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6 control", 32'(control), 32'd0);
    check("t6 number", 32'(number), 32'd0);
    check("t6 busy", 32'(busy), 32'd0);
    check("t6 tx_count", 32'(tx_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    r = {sw_req, key_req};
    for (int i = 0; i < 11; i++) begin
      ix = 4'(i);
      capture({r[ix], ix}, $sformatf("t6 cmd%0d", i), i > 0, -1, 8'h00, 1'b0);
    end
    wait_idle("t6");
    check("t6 final tx_count", 32'(tx_count), 32'd11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/virtual_input_tx.md
Name: virtual_input_tx

Overview:
- Transmit end of the 5-bit `number` / 1-bit `control` virtual-input link.
- Tracks the requested state of 3 keys and 8 switches, and a shadow copy of what the far end currently holds.
- Sends one command per mismatched item until the shadow equals the request.
- Sits between a host-side request register (JTAG/test logic) and the virtual-input receiver that drives KEY/SW into the NIOS system.

Parameters:
- SETUP_CYCLES, 1: cycles `number` is stable before `control` rises (min 1).
- HOLD_CYCLES, 4: cycles `control` stays high per command (min 1).
- GAP_CYCLES, 2: cycles `control` stays low after a command before the next may start (min 1).
- CNT_W, 16: width of the command counter.

Ports:
- CLOCK_50, input, 1: system clock; all state on rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- key_req, input, 3: requested key levels, index 0..2.
- sw_req, input, 8: requested switch levels, index 3..10 (sw_req[i] is item 3+i).
- resync, input, 1: single-cycle pulse; forces retransmission of all 11 items.
- number, output, 5: command word. Bit 4 is the value; bits 3:0 are the item index 0..10.
- control, output, 1: command strobe. The receiver acts while it is high.
- busy, output, 1: high whenever the FSM is not in IDLE.
- tx_count, output, CNT_W: number of commands completed; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: number=0, control=0, busy=0, tx_count=0.
  - Internal state: shadow[10:0]=0, force[10:0]=all ones, ptr=0, state=IDLE.
  - Effect: the first activity after reset pushes the full current request.
- Item vector: req = {sw_req, key_req} (11 bits). pending = (req ^ shadow) | force.
- IDLE:
  - If pending is zero, stay in IDLE.
  - Otherwise select idx = the first set bit of pending at or after ptr, wrapping 10→0.
  - Latch val=req[idx], drive number={val, idx[3:0]} and go to SETUP.
  - Selection takes 1 cycle; control stays 0.
- SETUP: control=0, number held for SETUP_CYCLES, then go to STROBE.
- STROBE:
  - control=1 and number held for exactly HOLD_CYCLES.
  - On the last cycle: shadow[idx]<=val, force[idx]<=0, ptr<=(idx==10)?0:idx+1, tx_count<=tx_count+1.
  - Then go to GAP.
- GAP: control=0, number held for GAP_CYCLES, then go to IDLE.
- number changes only on IDLE→SETUP. It is never changed while control=1.
- Indices 11..15 are never emitted.
- Minimum command period = 1+SETUP_CYCLES+HOLD_CYCLES+GAP_CYCLES cycles (8 at defaults).
- Request change mid-command: the latched val is still sent. The mismatch is picked up by the next IDLE evaluation.
- Request glitch that returns to the shadow value before IDLE: no command is sent, unless the force bit is set.
- resync:
  - Sets force to all ones in the cycle it is seen; it does not abort the current command.
  - If resync coincides with the last STROBE cycle, the set wins for that idx, so the item is resent.
- Round-robin via ptr guarantees every pending item is served within 11 commands, even if one item toggles continuously.
- Reset mid-operation: control drops to 0 immediately (async) and the full-state push restarts.
- Counter wraps from all-ones to 0 with no flag.

Decomposition:
- Shared package `vin_pkg`:
  - Constants: N_KEYS=3, N_SWITCHES=8, N_ITEMS=11, KEY_BASE=0, SW_BASE=3, IDX_W=4.
  - Value-bit position: 4.
  - State enum: IDLE, SETUP, STROBE, GAP.
  - The receiver uses the same package.
- Sub-module `rr_pick`: combinational 11-bit round-robin selector. Inputs are the request vector and a start pointer; outputs are the index and a valid flag. It is instantiated once and unit-tested separately.
- The phase-length down-counter stays in the main FSM.

Test Plan:
1. Reset with key_req=0, sw_req=0, no further stimulus: 11 commands 0x00..0x0A in order, control high 4 cycles each, 8-cycle period, then busy=0 and tx_count=11.
2. After idle, set sw_req=8'h01: exactly one command, number=0x13, control high 4 cycles, shadow[3]=1, tx_count+1.
3. Clear sw_req[0] back to 0 during the STROBE of case 2: 0x13 completes unchanged, then 0x03 is sent; number is stable throughout both strobes.
4. With ptr=4 and idle, set key_req[2]=1 and sw_req[7]=1 in the same cycle: 0x1A is sent first, then 0x12.
5. Assert resync during the GAP of an unrelated command: all 11 items are resent with their current req values, and the in-flight command is not truncated.
6. Assert reset_n=0 mid-STROBE: control and number go to 0 without waiting for a clock. After release, the full 11-command push repeats with tx_count restarted from 0.
